data_memory_hs: RTL and testbench

Parametrised, handshaked successor to the single-cycle data memory: a byte-addressable, little-endian RAM with byte-mask writes, a registered synchronous read, and a valid/ready request port. The memory is built as four byte lanes. Accesses that cross a 32-bit word boundary are split internally into two beats. Addresses outside the configured depth are flagged instead of silently aliased. The block sits behind the load/store unit as the data-side memory.

---
 rtl/data_memory_hs.sv | 188 ++++++++++++++++++
 tb/tb_data_memory_hs.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-addressable little-endian RAM built from four byte lanes, valid/ready request port.
// Latency: response one cycle after acceptance; two cycles when the access crosses a word boundary.
// Backpressure: o_req_ready drops for the second beat of a split access; responses cannot be stalled.
module data_memory_hs #(
    parameter int DEPTH_BYTES = 2048
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_wren,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [3:0]  i_bmask,
    output logic        o_rsp_valid,
    output logic [31:0] o_rdata,
    output logic        o_rsp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int WW = AW - 2;
    localparam int NW = DEPTH_BYTES / 4;

    typedef enum logic {IDLE, BEAT2} state_t;

    // Rotate right by whole bytes: lane view -> request byte order.
    function automatic logic [31:0] rotr_bytes(input logic [31:0] v, input logic [1:0] s);
        logic [63:0] t;
        t = {v, v} >> {s, 3'b000};
        return t[31:0];
    endfunction

    // Rotate left by whole bytes: request byte order -> lane view.
    function automatic logic [31:0] rotl_bytes(input logic [31:0] v, input logic [1:0] s);
        logic [63:0] t;
        t = {v, v} << {s, 3'b000};
        return t[63:32];
    endfunction

    logic [7:0] lane_mem [4][NW];

    state_t        state_q, state_d;
    logic          up_q, up_d;
    logic [WW-1:0] word2_q, word2_d;
    logic [3:0]    hi_mask_q, hi_mask_d;
    logic [31:0]   wrot_q, wrot_d;
    logic [1:0]    off_q, off_d;
    logic          wren_q, wren_d;
    logic [31:0]   hold_q, hold_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          accept;
    logic [1:0]    req_off;
    logic [WW-1:0] req_word;
    logic          req_err;
    logic [7:0]    req_mask;
    logic          req_split;
    logic [31:0]   req_wrot;

    logic          mem_we;
    logic [3:0]    mem_lanes;
    logic [WW-1:0] mem_word;
    logic [31:0]   mem_wdata;
    logic [31:0]   rd_raw;
    logic [31:0]   lane_gather;

    // up_q holds ready low until the first edge after reset release.
    assign o_req_ready = up_q && (state_q == IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rdata     = rdata_q;
    assign o_rsp_err   = rsp_err_q;

    // Decode the incoming request: lane offset, word, range error, shifted mask.
    always_comb begin
        accept    = i_req_valid && o_req_ready;
        req_off   = i_addr[1:0];
        req_word  = i_addr[AW-1:2];
        req_err   = |i_addr[31:AW];
        req_mask  = {4'b0000, i_bmask} << req_off;
        req_split = (|req_mask[7:4]) && !req_err;
        req_wrot  = rotl_bytes(i_wdata, req_off);
    end

    // Memory port: beat 2 replays the stored request on the next word, else the live request drives it.
    always_comb begin
        if (state_q == BEAT2) begin
            mem_word  = word2_q;
            mem_lanes = hi_mask_q;
            mem_wdata = wrot_q;
            mem_we    = wren_q;
        end else begin
            mem_word  = req_word;
            mem_lanes = (accept && !req_err) ? req_mask[3:0] : 4'b0000;
            mem_wdata = req_wrot;
            mem_we    = accept && i_req_wren && !req_err;
        end
    end

    // Read all four lanes at the selected word and keep only the enabled ones.
    always_comb begin
        rd_raw = '0;
        for (int l = 0; l < 4; l++) begin
            rd_raw[8*l +: 8] = lane_mem[l][mem_word];
        end
        lane_gather = rd_raw & {{8{mem_lanes[3]}}, {8{mem_lanes[2]}},
                                {8{mem_lanes[1]}}, {8{mem_lanes[0]}}};
    end

    // Byte-lane writes; storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < 4; l++) begin
            if (mem_we && mem_lanes[l]) begin
                lane_mem[l][mem_word] <= mem_wdata[8*l +: 8];
            end
        end
    end

    // Next state: single beats respond immediately, split accesses park beat-1 lanes for one cycle.
    always_comb begin
        state_d     = state_q;
        up_d        = 1'b1;
        word2_d     = word2_q;
        hi_mask_d   = hi_mask_q;
        wrot_d      = wrot_q;
        off_d       = off_q;
        wren_d      = wren_q;
        hold_d      = hold_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_split) begin
                        state_d   = BEAT2;
                        word2_d   = req_word + WW'(1);
                        hi_mask_d = req_mask[7:4];
                        wrot_d    = req_wrot;
                        off_d     = req_off;
                        wren_d    = i_req_wren;
                        hold_d    = lane_gather;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = req_err;
                        rdata_d     = i_req_wren ? 32'h0 : rotr_bytes(lane_gather, req_off);
                    end
                end
            end
            BEAT2: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rdata_d     = wren_q ? 32'h0 : rotr_bytes(hold_q | lane_gather, off_q);
            end
            default: state_d = IDLE;
        endcase
    end

    // State and response registers; reset abandons any pending second beat.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= IDLE;
            up_q        <= 1'b0;
            word2_q     <= '0;
            hi_mask_q   <= 4'b0000;
            wrot_q      <= 32'h0;
            off_q       <= 2'b00;
            wren_q      <= 1'b0;
            hold_q      <= 32'h0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            up_q        <= up_d;
            word2_q     <= word2_d;
            hi_mask_q   <= hi_mask_d;
            wrot_q      <= wrot_d;
            off_q       <= off_d;
            wren_q      <= wren_d;
            hold_q      <= hold_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end
endmodule

// File: tb/tb_data_memory_hs.sv
// tb_data_memory_hs: byte-array reference model with a per-cycle response/ready checker.
// Latency: expected responses are scheduled one or two cycles after acceptance.
// Backpressure: the driver only presents a request once o_req_ready is high.
module tb_data_memory_hs;
    localparam int DEPTH = 2048;
    localparam int AW    = 11;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_wren = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic [3:0]  i_bmask = 4'h0;
    logic        o_rsp_valid;
    logic [31:0] o_rdata;
    logic        o_rsp_err;

    data_memory_hs #(.DEPTH_BYTES(DEPTH)) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .o_req_ready (o_req_ready),
        .i_req_wren  (i_req_wren),
        .i_addr      (i_addr),
        .i_wdata     (i_wdata),
        .i_bmask     (i_bmask),
        .o_rsp_valid (o_rsp_valid),
        .o_rdata     (o_rdata),
        .o_rsp_err   (o_rsp_err)
    );

    typedef struct {
        int          due;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        cur;
    logic [7:0]  model_mem [DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          busy_cyc = -1;
    bit          chk_en = 1'b0;
    bit          chk_ready = 1'b0;
    logic [31:0] seen_rdata = 32'h0;
    logic        seen_err = 1'b0;
    int          seen_cnt = 0;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: every byte k of the access is model_mem[(a+k) mod DEPTH]; a beat-1-only
    // write stops at the end of the starting word.
    function automatic void model_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                         input logic [3:0] bm, input bit beat1_only,
                                         output logic [31:0] rd, output logic err, output bit split);
        int off;
        int idx;
        off   = int'(a[1:0]);
        err   = (a >= 32'(DEPTH));
        split = 1'b0;
        rd    = 32'h0;
        if (!err) begin
            for (int k = 0; k < 4; k++) begin
                if (bm[k]) begin
                    if (off + k >= 4) split = 1'b1;
                    idx = (int'(a[AW-1:0]) + k) % DEPTH;
                    if (wr) begin
                        if (!beat1_only || off + k < 4) model_mem[idx] = wd[8*k +: 8];
                    end else begin
                        rd[8*k +: 8] = model_mem[idx];
                    end
                end
            end
        end
        if (wr) rd = 32'h0;
    endfunction

    // Present one request, apply it to the model at acceptance, schedule its response.
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] bm, input bit track);
        int          g;
        logic [31:0] rd;
        logic        er;
        bit          sp;
        rsp_t        e;
        g = 0;
        while (o_req_ready !== 1'b1 && g < 10) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (o_req_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: ready=%b, expected 1 within 10 cycles", o_req_ready);
            return;
        end
        i_req_valid = 1'b1;
        i_req_wren  = wr;
        i_addr      = a;
        i_wdata     = wd;
        i_bmask     = bm;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        model_access(wr, a, wd, bm, !track, rd, er, sp);
        if (track) begin
            e.due   = sp ? cyc + 1 : cyc;
            e.rdata = rd;
            e.err   = er;
            exp_q.push_back(e);
        end
        if (sp) busy_cyc = cyc;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 10) begin
            @(posedge i_clk); #1;
            g++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Per-cycle compare: response pulses exactly when scheduled, silent otherwise; ready low only in beat 2.
    always @(negedge i_clk) begin
        if (chk_en) begin
            if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
                checks++;
                errors++;
                $display("FAIL rsp_lost: response due at cycle %0d never checked", exp_q[0].due);
                void'(exp_q.pop_front());
            end
            if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
                cur = exp_q.pop_front();
                chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
                chk("rsp_rdata", o_rdata, cur.rdata);
                chk("rsp_err", 32'(o_rsp_err), 32'(cur.err));
                seen_rdata = o_rdata;
                seen_err   = o_rsp_err;
                seen_cnt++;
            end else begin
                chk("rsp_idle", 32'(o_rsp_valid), 32'd0);
            end
            if (chk_ready) chk("req_ready", 32'(o_req_ready), (cyc == busy_cyc) ? 32'd0 : 32'd1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int n0;
        repeat (3) @(posedge i_clk);
        #1;
        chk("reset_ready", 32'(o_req_ready), 32'd0);
        chk("reset_valid", 32'(o_rsp_valid), 32'd0);
        chk("reset_rdata", o_rdata, 32'h0);
        chk("reset_err", 32'(o_rsp_err), 32'd0);
        i_reset = 1'b1;
        #1;
        chk("ready_before_edge", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        chk("ready_after_release", 32'(o_req_ready), 32'd1);
        chk_en    = 1'b1;
        chk_ready = 1'b1;

        // Known contents everywhere so the model can predict every read.
        for (int w = 0; w < DEPTH / 4; w++) issue(1'b1, 32'(w * 4), $urandom, 4'hF, 1'b1);
        drain();

        // Aligned word.
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b1);
        drain();
        chk("aligned_wr_err", 32'(seen_err), 32'd0);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        drain();
        chk("aligned_rd", seen_rdata, 32'hDEADBEEF);

        // Byte and half masks.
        issue(1'b1, 32'h23, 32'h000000AA, 4'h1, 1'b1);
        issue(1'b0, 32'h20, 32'h0, 4'hF, 1'b1);
        drain();
        chk("byte_wr_top", 32'(seen_rdata[31:24]), 32'hAA);
        issue(1'b0, 32'h20, 32'h0, 4'h3, 1'b1);
        drain();
        chk("half_rd_upper_zero", 32'(seen_rdata[31:16]), 32'h0);

        // Word-crossing split.
        issue(1'b1, 32'h0E, 32'h44332211, 4'hF, 1'b1);
        issue(1'b0, 32'h0C, 32'h0, 4'hF, 1'b1);
        drain();
        chk("split_lo_word", 32'(seen_rdata[31:16]), 32'h2211);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        drain();
        chk("split_hi_word", 32'(seen_rdata[15:0]), 32'h4433);
        issue(1'b0, 32'h0E, 32'h0, 4'hF, 1'b1);
        drain();
        chk("split_rd", seen_rdata, 32'h44332211);

        // Wrap from the top of memory to word 0.
        issue(1'b1, 32'h7FE, 32'hCAFEF00D, 4'hF, 1'b1);
        drain();
        chk("wrap_wr_err", 32'(seen_err), 32'd0);
        issue(1'b0, 32'h7FE, 32'h0, 4'h3, 1'b1);
        drain();
        chk("wrap_top_bytes", seen_rdata, 32'h0000F00D);
        issue(1'b0, 32'h000, 32'h0, 4'h3, 1'b1);
        drain();
        chk("wrap_low_bytes", seen_rdata, 32'h0000CAFE);
        issue(1'b0, 32'h7FE, 32'h0, 4'hF, 1'b1);
        drain();
        chk("wrap_rd", seen_rdata, 32'hCAFEF00D);

        // Out of range.
        issue(1'b1, 32'h800, 32'h12345678, 4'hF, 1'b1);
        drain();
        chk("oor_wr_err", 32'(seen_err), 32'd1);
        chk("oor_wr_rdata", seen_rdata, 32'h0);
        issue(1'b0, 32'h000, 32'h0, 4'h3, 1'b1);
        drain();
        chk("oor_no_alias", seen_rdata, 32'h0000CAFE);
        issue(1'b0, 32'h8000_0000, 32'h0, 4'hF, 1'b1);
        drain();
        chk("oor_rd_err", 32'(seen_err), 32'd1);

        // Back-to-back aligned reads.
        c0 = cyc;
        n0 = seen_cnt;
        for (int i = 0; i < 8; i++) issue(1'b0, 32'(i * 4 + 32'h40), 32'h0, 4'hF, 1'b1);
        chk("b2b_cycles", 32'(cyc - c0), 32'd8);
        drain();
        chk("b2b_responses", 32'(seen_cnt - n0), 32'd8);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [31:0] a;
            r = int'($urandom_range(0, 19));
            if (r == 0)      a = $urandom;
            else if (r == 1) a = 32'(DEPTH) + 32'($urandom_range(0, 7));
            else if (r < 5)  a = 32'(DEPTH - 8) + 32'($urandom_range(0, 7));
            else             a = 32'($urandom_range(0, DEPTH - 1));
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge i_clk); #1;
            end
        end
        drain();

        // Reset during the second beat of a split write.
        issue(1'b1, 32'h20, 32'h55667788, 4'hF, 1'b1);
        issue(1'b0, 32'h10, 32'h0, 4'hF, 1'b1);
        drain();
        chk_ready = 1'b0;
        issue(1'b1, 32'h1E, 32'hA1B2C3D4, 4'hF, 1'b0);
        i_reset = 1'b0;
        #1;
        chk("rst_b2_ready", 32'(o_req_ready), 32'd0);
        chk("rst_b2_valid", 32'(o_rsp_valid), 32'd0);
        chk("rst_b2_rdata", o_rdata, 32'h0);
        chk("rst_b2_err", 32'(o_rsp_err), 32'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        #1;
        chk("rst_b2_ready_held", 32'(o_req_ready), 32'd0);
        @(posedge i_clk); #1;
        chk("rst_b2_ready_up", 32'(o_req_ready), 32'd1);
        chk_ready = 1'b1;
        issue(1'b0, 32'h1C, 32'h0, 4'hF, 1'b1);
        drain();
        chk("rst_b2_beat1_kept", 32'(seen_rdata[31:16]), 32'hC3D4);
        issue(1'b0, 32'h20, 32'h0, 4'h3, 1'b1);
        drain();
        chk("rst_b2_beat2_dropped", seen_rdata, 32'h00007788);

        repeat (3) @(posedge i_clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
